// File: rtl/pit_dncnt_pkg.sv
// Shared definitions for the programmable interval timer (pit_dncnt).
//   MODE_ONESHOT / MODE_PERIODIC : values of the mode input
//   PRE_W_DEF / DIV_W_DEF        : default counter widths
//   run_state_t                  : armed/idle state of the timer
package pit_dncnt_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int unsigned PRE_W_DEF = 16;
    localparam int unsigned DIV_W_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

endpackage

// File: rtl/pit_dncnt_dncnt_n.sv
// W-bit loadable down counter with a reload register.
//   clk, reset : clock, async active-high reset (clears count and reload)
//   din        : load data
//   ld         : reload reg and count take din (highest priority)
//   restart    : count takes the reload value
//   step       : count down one; at zero either reload (wrap=1) or hold (wrap=0)
//   wrap       : reload-on-zero enable
//   q          : current count
//   zero_c     : count is zero (combinational)
//   bo_c       : borrow out, step while at zero (combinational)
module dncnt_n #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         ld,
    input  logic         restart,
    input  logic         step,
    input  logic         wrap,
    output logic [W-1:0] q,
    output logic         zero_c,
    output logic         bo_c
);

    logic [W-1:0] rel;

    // Count/reload register; never wraps below zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rel <= '0;
            q   <= '0;
        end else if (ld) begin
            rel <= din;
            q   <= din;
        end else if (restart) begin
            q <= rel;
        end else if (step) begin
            if (zero_c) begin
                if (wrap) begin
                    q <= rel;
                end
            end else begin
                q <= q - W'(1);
            end
        end
    end

    assign zero_c = (q == '0);
    assign bo_c   = step & zero_c;

endmodule

// File: rtl/pit_dncnt.sv
// Programmable interval timer: prescaler feeding a divider, periodic or one-shot,
// with a registered expiry pulse and a sticky interrupt.
//   clk, reset : clock, async active-high reset (clears all state)
//   din        : load data, LSBs used per counter
//   pre_ld     : load prescaler reload and count
//   div_ld     : load divider reload and count, restart prescaler, arm timer
//   en         : count enable
//   mode       : 0 one-shot, 1 periodic
//   irq_ack    : clear irq
//   pre_q      : prescaler count
//   div_q      : divider count
//   run        : timer armed
//   co         : combinational expiry strobe
//   tick       : registered one-cycle expiry pulse
//   irq        : sticky interrupt request
module pit_dncnt
    import pit_dncnt_pkg::*;
#(
    parameter  int unsigned PRE_W = PRE_W_DEF,
    parameter  int unsigned DIV_W = DIV_W_DEF,
    localparam int unsigned DIN_W = (PRE_W > DIV_W) ? PRE_W : DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIN_W-1:0] din,
    input  logic             pre_ld,
    input  logic             div_ld,
    input  logic             en,
    input  logic             mode,
    input  logic             irq_ack,
    output logic [PRE_W-1:0] pre_q,
    output logic [DIV_W-1:0] div_q,
    output logic             run,
    output logic             co,
    output logic             tick,
    output logic             irq
);

    run_state_t state, state_nxt;
    logic       pb;
    logic       div_bo;
    logic       pre_zero;
    logic       div_zero;

    // Prescaler: free-runs while armed and enabled, always reloads at zero
    dncnt_n #(.W(PRE_W)) u_pre (
        .clk     (clk),
        .reset   (reset),
        .din     (din[PRE_W-1:0]),
        .ld      (pre_ld),
        .restart (div_ld),
        .step    (run & en),
        .wrap    (1'b1),
        .q       (pre_q),
        .zero_c  (pre_zero),
        .bo_c    (pb)
    );

    // Divider: steps on prescaler borrow; reloads at zero only in periodic mode
    dncnt_n #(.W(DIV_W)) u_div (
        .clk     (clk),
        .reset   (reset),
        .din     (din[DIV_W-1:0]),
        .ld      (div_ld),
        .restart (1'b0),
        .step    (pb),
        .wrap    (mode == MODE_PERIODIC),
        .q       (div_q),
        .zero_c  (div_zero),
        .bo_c    (div_bo)
    );

    // A divider load on the expiry cycle suppresses that expiry
    assign co  = div_bo & ~div_ld;
    assign run = (state == ST_RUN);

    // Armed-state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arm on divider load, disarm on one-shot expiry
    always_comb begin
        state_nxt = state;
        if (div_ld) begin
            state_nxt = ST_RUN;
        end else if (co && (mode == MODE_ONESHOT)) begin
            state_nxt = ST_IDLE;
        end
    end

    // Expiry pulse and sticky interrupt; a set beats a simultaneous ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick <= 1'b0;
            irq  <= 1'b0;
        end else begin
            tick <= co;
            if (tick) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pit_dncnt.sv
// Directed bench for pit_dncnt: vector table for the first P=2/D=3 period,
// then hand-written sequences for the multi-cycle corner cases.
module tb_pit_dncnt;
    import pit_dncnt_pkg::*;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         pre_ld, div_ld, en, mode, irq_ack;
    logic [W-1:0] pre_q, div_q;
    logic         run, co, tick, irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pit_dncnt #(.PRE_W(W), .DIV_W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .pre_ld  (pre_ld),
        .div_ld  (div_ld),
        .en      (en),
        .mode    (mode),
        .irq_ack (irq_ack),
        .pre_q   (pre_q),
        .div_q   (div_q),
        .run     (run),
        .co      (co),
        .tick    (tick),
        .irq     (irq)
    );

    typedef struct {
        logic         rst, p_ld, d_ld;
        logic [W-1:0] d;
        logic         e, m, ack;
        logic [W-1:0] x_pre, x_div;
        logic         x_run, x_tick, x_irq, x_co;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic rst, input logic p_ld, input logic d_ld,
                                input logic [W-1:0] d, input logic e, input logic m,
                                input logic ack, input logic [W-1:0] x_pre,
                                input logic [W-1:0] x_div, input logic x_run,
                                input logic x_tick, input logic x_irq, input logic x_co);
        vec_t v;
        v.rst = rst; v.p_ld = p_ld; v.d_ld = d_ld; v.d = d; v.e = e; v.m = m; v.ack = ack;
        v.x_pre = x_pre; v.x_div = x_div; v.x_run = x_run; v.x_tick = x_tick;
        v.x_irq = x_irq; v.x_co = x_co;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Clock until tick is seen after an edge; n is the number of edges taken
    task automatic wait_tick(input int bound, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < bound);
    endtask

    task automatic ld(input logic p, input logic d, input logic [W-1:0] v);
        pre_ld = p;
        div_ld = d;
        din    = v;
        cyc();
        pre_ld = 1'b0;
        div_ld = 1'b0;
    endtask

    initial begin
        int n;
        int nt;
        int ni;

        reset = 1'b1; din = '0; pre_ld = 1'b0; div_ld = 1'b0;
        en = 1'b0; mode = MODE_PERIODIC; irq_ack = 1'b0;

        // rst pld dld din en mode ack | pre div run tick irq co(before edge)
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b1, 1'b0, 16'd2, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 16'd2, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 16'd0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            reset = vecs[i].rst; pre_ld = vecs[i].p_ld; div_ld = vecs[i].d_ld;
            din = vecs[i].d; en = vecs[i].e; mode = vecs[i].m; irq_ack = vecs[i].ack;
            #1;
            chk($sformatf("vec%0d co", i), 32'(co), 32'(vecs[i].x_co));
            cyc();
            chk($sformatf("vec%0d pre_q", i), 32'(pre_q), 32'(vecs[i].x_pre));
            chk($sformatf("vec%0d div_q", i), 32'(div_q), 32'(vecs[i].x_div));
            chk($sformatf("vec%0d run", i), 32'(run), 32'(vecs[i].x_run));
            chk($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].x_tick));
            chk($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].x_irq));
        end
        pre_ld = 1'b0; div_ld = 1'b0; irq_ack = 1'b0;

        // Periodic P=2,D=3: next tick 12 edges after the table's tick
        wait_tick(100, n);
        chk("periodic_next_tick", 32'(n), 32'd10);
        irq_ack = 1'b1;
        cyc();
        chk("ack_with_tick_irq", 32'(irq), 32'd1);
        cyc();
        chk("ack_alone_irq", 32'(irq), 32'd0);
        irq_ack = 1'b0;
        wait_tick(100, n);
        chk("periodic_gap_a", 32'(n), 32'd10);
        wait_tick(100, n);
        chk("periodic_period", 32'(n), 32'd12);

        // One-shot P=2,D=3: single tick, run drops at expiry, div holds 0
        mode = MODE_ONESHOT;
        ld(1'b0, 1'b1, 16'd3);
        wait_tick(100, n);
        chk("oneshot_first", 32'(n), 32'd12);
        chk("oneshot_run", 32'(run), 32'd0);
        chk("oneshot_div", 32'(div_q), 32'd0);
        chk("oneshot_pre", 32'(pre_q), 32'd2);
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (tick) nt++;
        end
        chk("oneshot_no_more_ticks", 32'(nt), 32'd0);
        chk("oneshot_div_hold", 32'(div_q), 32'd0);

        // Zero reloads: tick every cycle, then P=0,D=4 period 5
        mode = MODE_PERIODIC;
        ld(1'b1, 1'b1, 16'd0);
        chk("zero_pre", 32'(pre_q), 32'd0);
        chk("zero_div", 32'(div_q), 32'd0);
        chk("zero_run", 32'(run), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("zero_tick%0d", i), 32'(tick), 32'd1);
        end
        ld(1'b0, 1'b1, 16'd4);
        chk("divld_on_expiry_p0_tick", 32'(tick), 32'd0);
        wait_tick(100, n);
        chk("p0_d4_first", 32'(n), 32'd5);
        wait_tick(100, n);
        chk("p0_d4_period", 32'(n), 32'd5);

        // Enable low 7 cycles mid-period delays the tick by 7
        ld(1'b1, 1'b0, 16'd2);
        ld(1'b0, 1'b1, 16'd3);
        for (int i = 0; i < 4; i++) cyc();
        chk("pre_before_freeze", 32'(pre_q), 32'd1);
        chk("div_before_freeze", 32'(div_q), 32'd2);
        en = 1'b0;
        nt = 0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (tick) nt++;
        end
        chk("freeze_pre", 32'(pre_q), 32'd1);
        chk("freeze_div", 32'(div_q), 32'd2);
        chk("freeze_run", 32'(run), 32'd1);
        chk("freeze_no_tick", 32'(nt), 32'd0);
        en = 1'b1;
        wait_tick(100, n);
        chk("freeze_remaining", 32'(n), 32'd8);

        // div_ld on the expiry cycle suppresses co and tick
        ld(1'b0, 1'b1, 16'd3);
        for (int i = 0; i < 11; i++) cyc();
        chk("pre_at_expiry", 32'(pre_q), 32'd0);
        chk("div_at_expiry", 32'(div_q), 32'd0);
        chk("co_at_expiry", 32'(co), 32'd1);
        div_ld = 1'b1;
        din = 16'd3;
        #1;
        chk("co_with_divld", 32'(co), 32'd0);
        cyc();
        div_ld = 1'b0;
        chk("divld_expiry_tick", 32'(tick), 32'd0);
        chk("divld_expiry_pre", 32'(pre_q), 32'd2);
        chk("divld_expiry_div", 32'(div_q), 32'd3);
        wait_tick(100, n);
        chk("after_divld_expiry", 32'(n), 32'd12);

        // Asynchronous reset mid-count with P=5,D=5
        ld(1'b1, 1'b0, 16'd5);
        ld(1'b0, 1'b1, 16'd5);
        for (int i = 0; i < 10; i++) cyc();
        chk("irq_before_reset", 32'(irq), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_pre", 32'(pre_q), 32'd0);
        chk("rst_div", 32'(div_q), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        nt = 0;
        ni = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (tick) nt++;
            if (irq) ni++;
        end
        chk("post_reset_ticks", 32'(nt), 32'd0);
        chk("post_reset_irq", 32'(ni), 32'd0);
        chk("post_reset_run", 32'(run), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
